mux_bank_reg: RTL and testbench

MUX_BANK_REG -- requirements
Module: mux_bank_reg

---
 rtl/mux_pkg.sv | 7 +
 rtl/mux_sel_counter.sv | 22 ++
 rtl/mux_bank_reg.sv | 60 ++++++
 tb/tb_mux_bank_reg.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared mode type for the select-scanning mux bank.
package mux_pkg;
  typedef enum logic {
    MUX_DIRECT = 1'b0,
    MUX_SCAN   = 1'b1
  } mux_mode_e;
endpackage

// File: rtl/mux_sel_counter.sv
// mux_sel_counter: W-bit load/increment/hold counter with terminal-count flag.
module mux_sel_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         inc,
  input  logic [0:W-1] ld_val,
  output logic [0:W-1] cnt,
  output logic         tc
);
  logic [0:W-1] cnt_q, cnt_d;
  always_comb cnt_d = ld ? ld_val : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
  // range is a power of two, so all-ones is the last index
  assign tc  = &cnt_q;
endmodule

// File: rtl/mux_bank_reg.sv
// mux_bank_reg: NCH registered 1-of-NWAY selectors, driven by SEL directly or by a scanning counter.
module mux_bank_reg
  import mux_pkg::*;
#(
  parameter  int NCH  = 2,
  parameter  int NWAY = 4,
  localparam int SELW = $clog2(NWAY)
) (
  input  logic                       clk,
  input  logic                       RESET,
  input  logic                       EN,
  input  logic                       SCAN,
  input  logic [0:SELW-1]            SEL,
  input  logic [0:NCH-1][0:NWAY-1]   D,
  output logic [0:NCH-1]             B,
  output logic [0:SELW-1]            SELQ,
  output logic                       WRAP
);
  mux_mode_e       mode_q, mode_d;
  logic [0:NCH-1]  b_q, b_d, sel_bit;
  logic [0:SELW-1] selq_q, selq_d, idx, cnt;
  logic            wrap_q, wrap_d, tc, scanning;
  // scan entry (mode still DIRECT) uses SEL; only an established scan follows the counter
  assign scanning = SCAN && (mode_q == MUX_SCAN);
  assign idx      = scanning ? cnt : SEL;
  mux_sel_counter #(.W(SELW)) u_cnt (
    .clk    (clk),
    .rst    (RESET),
    .ld     (EN && !scanning),
    .inc    (EN && scanning),
    .ld_val (SEL + SELW'(SCAN)),
    .cnt    (cnt),
    .tc     (tc)
  );
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign sel_bit[c] = D[c][idx];
  end
  always_comb begin
    b_d    = EN ? sel_bit : b_q;
    selq_d = EN ? idx : selq_q;
    wrap_d = EN && scanning && tc;
    mode_d = EN ? (SCAN ? MUX_SCAN : MUX_DIRECT) : mode_q;
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      b_q    <= '0;
      selq_q <= '0;
      wrap_q <= 1'b0;
      mode_q <= MUX_DIRECT;
    end else begin
      b_q    <= b_d;
      selq_q <= selq_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
    end
  end
  assign B    = b_q;
  assign SELQ = selq_q;
  assign WRAP = wrap_q;
endmodule

// File: tb/tb_mux_bank_reg.sv
// tb_mux_bank_reg: directed checks on the default bank, randomized scoreboard on a 5x16 bank.
module tb_mux_bank_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             a_rst, a_en, a_scan;
  logic [0:1]       a_sel;
  logic [0:1][0:3]  a_d;
  logic [0:1]       a_b;
  logic [0:1]       a_selq;
  logic             a_wrap;

  logic             r_rst, r_en, r_scan;
  logic [0:3]       r_sel;
  logic [0:4][0:15] r_d;
  logic [0:4]       r_b;
  logic [0:3]       r_selq;
  logic             r_wrap;

  mux_bank_reg dut_a (
    .clk(clk), .RESET(a_rst), .EN(a_en), .SCAN(a_scan), .SEL(a_sel),
    .D(a_d), .B(a_b), .SELQ(a_selq), .WRAP(a_wrap)
  );

  mux_bank_reg #(.NCH(5), .NWAY(16)) dut_r (
    .clk(clk), .RESET(r_rst), .EN(r_en), .SCAN(r_scan), .SEL(r_sel),
    .D(r_d), .B(r_b), .SELQ(r_selq), .WRAP(r_wrap)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected B for the default bank: channel 0 data 0110, channel 1 data 1001, read MSB-first by index
  function automatic logic [1:0] exp_b(input int s);
    logic [3:0] d0, d1;
    d0 = 4'b0110;
    d1 = 4'b1001;
    return {d0[3-s], d1[3-s]};
  endfunction

  // reference state for the randomized bank
  bit       m_scan_mode;
  int       m_cnt, m_selq;
  bit       m_wrap;
  bit [4:0] m_b;

  function automatic bit dbit(input logic [79:0] flat, input int c, input int k);
    return flat[79 - (c * 16 + k)];
  endfunction

  initial begin
    int exp_selq [6] = '{2, 3, 0, 1, 2, 3};
    int exp_wrap [6] = '{0, 1, 0, 0, 0, 1};
    logic [79:0] flat;
    int idx;
    a_rst = 1; a_en = 1; a_scan = 1; a_sel = 2'd3; a_d = '1;
    r_rst = 1; r_en = 0; r_scan = 0; r_sel = '0; r_d = '0;
    step();
    chk("rst_b", a_b, 0);
    chk("rst_selq", a_selq, 0);
    chk("rst_wrap", a_wrap, 0);

    a_rst = 0; a_scan = 0; a_d = {4'b0110, 4'b1001};
    for (int s = 0; s < 4; s++) begin
      a_sel = s[1:0];
      step();
      chk($sformatf("direct_b%0d", s), a_b, exp_b(s));
      chk($sformatf("direct_selq%0d", s), a_selq, s);
      chk($sformatf("direct_wrap%0d", s), a_wrap, 0);
    end

    a_en = 0;
    for (int i = 0; i < 3; i++) begin
      a_d = 8'($urandom);
      a_sel = 2'(i);
      a_scan = i[0];
      step();
      chk($sformatf("hold_b%0d", i), a_b, 2'b01);
      chk($sformatf("hold_selq%0d", i), a_selq, 3);
      chk($sformatf("hold_wrap%0d", i), a_wrap, 0);
    end

    a_en = 1; a_scan = 1; a_sel = 2'd2; a_d = {4'b0110, 4'b1001};
    for (int i = 0; i < 6; i++) begin
      step();
      a_sel = 2'(i);
      chk($sformatf("scan_selq%0d", i), a_selq, exp_selq[i]);
      chk($sformatf("scan_wrap%0d", i), a_wrap, exp_wrap[i]);
      chk($sformatf("scan_b%0d", i), a_b, exp_b(exp_selq[i]));
    end
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_selq", a_selq, 2);
    a_rst = 1;
    step();
    chk("midscan_rst_b", a_b, 0);
    chk("midscan_rst_selq", a_selq, 0);
    chk("midscan_rst_wrap", a_wrap, 0);
    a_rst = 0; a_sel = 2'd1;
    step();
    chk("reentry_selq", a_selq, 1);
    chk("reentry_wrap", a_wrap, 0);
    step();
    chk("reentry_next_selq", a_selq, 2);
    a_scan = 0; a_sel = 2'd0;
    step();
    chk("scan_drop_selq", a_selq, 0);
    chk("scan_drop_wrap", a_wrap, 0);

    m_scan_mode = 0; m_cnt = 0; m_selq = 0; m_wrap = 0; m_b = '0;
    r_rst = 1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc > 0) begin
        r_rst  = ($urandom_range(0, 99) == 0);
        r_en   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 11) == 0) r_scan = ~r_scan;
        r_sel  = 4'($urandom);
      end
      flat = {$urandom, $urandom, 16'($urandom)};
      r_d  = flat;
      if (r_rst) begin
        m_scan_mode = 0; m_cnt = 0; m_selq = 0; m_wrap = 0; m_b = '0;
      end else if (r_en) begin
        if (!r_scan) begin
          idx = r_sel; m_cnt = r_sel; m_wrap = 0; m_scan_mode = 0;
        end else if (!m_scan_mode) begin
          idx = r_sel; m_cnt = (r_sel + 1) % 16; m_wrap = 0; m_scan_mode = 1;
        end else begin
          idx = m_cnt; m_wrap = (m_cnt == 15); m_cnt = (m_cnt + 1) % 16;
        end
        m_selq = idx;
        for (int c = 0; c < 5; c++) m_b[4 - c] = dbit(flat, c, idx);
      end else begin
        m_wrap = 0;
      end
      step();
      chk($sformatf("rand_b@%0d", cyc), r_b, m_b);
      chk($sformatf("rand_selq@%0d", cyc), r_selq, m_selq);
      chk($sformatf("rand_wrap@%0d", cyc), r_wrap, m_wrap);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
